shift_reg16_ctrl: RTL and testbench

//  Sequential 16-bit shift-register controller wrapped around the existing combinational
//  ror_shifter16 barrel rotator. Accepts load/rotate commands over a valid/ready handshake,

---
 rtl/shift_reg16_ctrl_pkg.sv | 31 +++
 rtl/shift_reg16_ctrl_ror.sv | 21 ++
 rtl/shift_reg16_ctrl.sv | 114 +++++++++++
 tb/tb_shift_reg16_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg16_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg16_ctrl_pkg
// Brief    : Shared opcodes, state encoding and helpers for shift_reg16_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package shift_reg16_ctrl_pkg;

    // Datapath width is tied to the 16-bit rotator and is fixed.
    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    // Command opcodes carried on cmd_op.
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROR  = 2'b01;
    localparam logic [1:0] OP_ROL  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // Controller states: accepting commands, or stepping a rotation.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // A left rotate by n equals a right rotate by (16 - n) mod 16.
    function automatic logic [AMT_W-1:0] rol_as_ror(input logic [AMT_W-1:0] amt);
        rol_as_ror = AMT_W'(5'd16 - {1'b0, amt});
    endfunction

endpackage : shift_reg16_ctrl_pkg
`default_nettype wire

// File: rtl/shift_reg16_ctrl_ror.sv
`default_nettype none
// ============================================================================
// Module   : ror_shifter16
// Brief    : Combinational 16-bit rotate-right barrel rotator
// Revision : 1.0 - initial release
// ============================================================================
module ror_shifter16
    import shift_reg16_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] s,
    output logic [WIDTH-1:0] dout
);

    // Output bit i takes input bit (i + s) mod 16; the 4-bit sum wraps naturally.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign dout[i] = din[AMT_W'(i) + s];
    end

endmodule : ror_shifter16
`default_nettype wire

// File: rtl/shift_reg16_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg16_ctrl
// Brief    : 16-bit shift-register controller around ror_shifter16. Accepts
//            LOAD/ROR/ROL/CLR over valid/ready and repeats rotations for a
//            programmable number of steps, with abort via stop.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg16_ctrl
    import shift_reg16_ctrl_pkg::*;
#(
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [REP_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [AMT_W-1:0]   amt_q,   amt_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   w_rot_q;

    // Rotator sees the held register and the latched per-step amount.
    ror_shifter16 u_ror (
        .din  (data_q),
        .s    (amt_q),
        .dout (w_rot_q)
    );

    // Next-state, datapath and done-pulse logic; stop outranks the step in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        amt_d   = amt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            data_d = cmd_data;
                            done_d = 1'b1;
                        end
                        OP_CLR: begin
                            data_d = '0;
                            done_d = 1'b1;
                        end
                        OP_ROR: begin
                            amt_d   = cmd_amt;
                            cnt_d   = (cmd_rep == '0) ? REP_W'(1) : cmd_rep;
                            state_d = S_RUN;
                        end
                        default: begin
                            amt_d   = rol_as_ror(cmd_amt);
                            cnt_d   = (cmd_rep == '0) ? REP_W'(1) : cmd_rep;
                            state_d = S_RUN;
                        end
                    endcase
                end
            end
            default: begin
                if (stop) begin
                    // Abort: keep the last completed step, no done pulse.
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    data_d = w_rot_q;
                    cnt_d  = cnt_q - REP_W'(1);
                    if (cnt_q == REP_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            amt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign q         = data_q;

endmodule : shift_reg16_ctrl
`default_nettype wire

// File: tb/tb_shift_reg16_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg16_ctrl
// Brief    : Directed self-checking bench for shift_reg16_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg16_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_amt;
    logic [7:0]  cmd_rep;
    logic        stop;
    logic [15:0] q;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    shift_reg16_ctrl #(.REP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .cmd_rep   (cmd_rep),
        .stop      (stop),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the full visible state in one call.
    task automatic chk_all(input string tag, input logic [15:0] eq, input logic eb,
                           input logic ed, input logic er);
        chk({tag, ".q"},     q,                 eq);
        chk({tag, ".busy"},  {15'd0, busy},      {15'd0, eb});
        chk({tag, ".done"},  {15'd0, done},      {15'd0, ed});
        chk({tag, ".ready"}, {15'd0, cmd_ready}, {15'd0, er});
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] amt, input logic [7:0] rep);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_amt   = amt;
        cmd_rep   = rep;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        cmd_amt = '0; cmd_rep = '0; stop = 1'b0;
        step(); step();
        chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        chk_all("reset_idle", 16'h0000, 1'b0, 1'b0, 1'b1);

        // 1: LOAD 1234, stop in IDLE is ignored
        issue(2'b00, 16'h1234, 4'd0, 8'd0); stop = 1'b1;
        step(); cmd_valid = 1'b0; stop = 1'b0;
        chk_all("t1_load", 16'h1234, 1'b0, 1'b1, 1'b1);
        step();
        chk_all("t1_after", 16'h1234, 1'b0, 1'b0, 1'b1);

        // 2: ROR 4 x1
        issue(2'b01, 16'hFFFF, 4'd4, 8'd1);
        step(); cmd_valid = 1'b0;
        chk_all("t2_e0", 16'h1234, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t2_e1", 16'h4123, 1'b0, 1'b1, 1'b1);

        // 3: LOAD 8001, ROL 4 x3 with a command pulsed while busy
        issue(2'b00, 16'h8001, 4'd0, 8'd0);
        step();
        chk("t3_load", q, 16'h8001);
        issue(2'b10, 16'h0000, 4'd4, 8'd3);
        step();
        chk_all("t3_e0", 16'h8001, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 16'hFFFF, 4'd0, 8'd0);
        step(); cmd_valid = 1'b0;
        chk_all("t3_e1", 16'h0018, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t3_e2", 16'h0180, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t3_e3", 16'h1800, 1'b0, 1'b1, 1'b1);

        // 4: LOAD 0001, ROR 1 rep 0, then ROL 0 x2
        issue(2'b00, 16'h0001, 4'd0, 8'd0);
        step();
        issue(2'b01, 16'h0000, 4'd1, 8'd0);
        step(); cmd_valid = 1'b0;
        chk_all("t4_e0", 16'h0001, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t4_e1", 16'h8000, 1'b0, 1'b1, 1'b1);
        issue(2'b10, 16'h0000, 4'd0, 8'd2);
        step(); cmd_valid = 1'b0;
        chk_all("t4b_e0", 16'h8000, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t4b_e1", 16'h8000, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t4b_e2", 16'h8000, 1'b0, 1'b1, 1'b1);

        // 5: LOAD ABCD, ROR 8 x5, stop on the 3rd RUN edge
        issue(2'b00, 16'hABCD, 4'd0, 8'd0);
        step();
        issue(2'b01, 16'h0000, 4'd8, 8'd5);
        step(); cmd_valid = 1'b0;
        step();
        chk_all("t5_e1", 16'hCDAB, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t5_e2", 16'hABCD, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step(); stop = 1'b0;
        chk_all("t5_stop", 16'hABCD, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("t5_after", 16'hABCD, 1'b0, 1'b0, 1'b1);

        // 6: ROR 3 x10 from ABCD, reset mid-run, then LOAD
        issue(2'b01, 16'h0000, 4'd3, 8'd10);
        step(); cmd_valid = 1'b0;
        step();
        chk("t6_e1", q, 16'hB579);
        step();
        rst_n = 1'b0;
        step(); rst_n = 1'b1;
        chk_all("t6_rst", 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 16'h5A5A, 4'd0, 8'd0);
        step(); cmd_valid = 1'b0;
        chk_all("t6_load", 16'h5A5A, 1'b0, 1'b1, 1'b1);

        // CLR
        issue(2'b11, 16'hFFFF, 4'd0, 8'd0);
        step(); cmd_valid = 1'b0;
        chk_all("clr", 16'h0000, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_reg16_ctrl
`default_nettype wire
